led_display_hub75_rx: RTL and testbench
=======================================

// Module: led_display_hub75_rx
// PURPOSE
//  Receive-side model of the HUB75 panel interface: samples the bit clock, RGB, latch, OE and row address
//  lines that the display driver PHY produces, and rebuilds per-pixel writes and per-line summaries.
//  Sits on the PHY output pins as a synthesizable loopback checker/scoreboard and as a panel model in sims.
//  Panel is NUM_COL_PIXELS wide and NUM_ROW_PIXELS tall, scanned as two halves (top/bottom) sharing an address.
// PARAMETERS
//  NUM_ROW_PIXELS  32  panel height; ADDR_W = $clog2(NUM_ROW_PIXELS/2)
//  NUM_COL_PIXELS  64  pixels shifted per line; COL_W = $clog2(NUM_COL_PIXELS)
//  SYNC_STAGES     2   input synchroniser depth (>=1), applied identically to all HUB75 inputs
// PORTS
//  clk_in            in   1        system clock
//  reset_in          in   1        synchronous, active-high reset
//  bclk_in           in   1        HUB75 bit clock; data valid on rising edge
//  rgb_top_in        in   3        {R,G,B} for top half
//  rgb_bot_in        in   3        {R,G,B} for bottom half
//  latch_in          in   1        line latch, active high
//  oe_n_in           in   1        output enable, active low
//  addr_in           in   ADDR_W   row address
//  pix_valid_out     out  1        one-cycle pulse per accepted pixel
//  pix_col_out       out  COL_W    column index of pixel
//  pix_top_rgb_out   out  3        captured top RGB
//  pix_bot_rgb_out   out  3        captured bottom RGB
//  line_valid_out    out  1        one-cycle pulse on latch rising edge
//  line_row_out      out  ADDR_W   addr_in sampled at latch edge
//  line_len_out      out  COL_W+1  bclk edges seen since previous latch
//  line_err_out      out  1        line_len != NUM_COL_PIXELS, or bclk edge while latch high
//  oe_valid_out      out  1        one-cycle pulse on oe_n rising edge
//  oe_time_out       out  16       clk cycles oe_n was low, saturating at 16'hFFFF
//  frame_cnt_out     out  16       completed frames, wraps
//  err_sticky_out    out  1        OR of all line_err since reset
// BEHAVIOUR
//  - Reset: all outputs 0; col counter 0; state IDLE; synchroniser flops 0 except oe_n stages = 1.
//  - All inputs pass through SYNC_STAGES flops, then one edge-detect register; edges evaluated on synced data.
//  - Latency: pix_valid_out/line_valid_out/oe_valid_out assert SYNC_STAGES+1 clks after the input edge is
//    first sampled by clk_in. Data outputs hold until next pulse of the same type.
//  - FSM: IDLE -> SHIFT on first bclk rise; SHIFT -> LATCH on latch rise; LATCH -> IDLE on latch fall.
//  - bclk rise in IDLE/SHIFT: if col < NUM_COL_PIXELS emit pixel at col, col++; else no pixel, overflow flag set.
//  - bclk rise in LATCH: no pixel, flags error for the next reported line.
//  - latch rise (any state): line_valid pulse, line_len = col (0..NUM_COL_PIXELS, saturating), line_err as above;
//    col and flags clear same cycle. latch rise in IDLE reports len 0, err 1.
//  - Simultaneous bclk rise and latch rise: pixel emitted first and counted in line_len of the same line.
//  - oe counter: counts cycles with synced oe_n = 0; on oe_n rise, pulse oe_valid with count, then clear.
//  - Frame: on line_valid, if line_row < previous line_row, frame_cnt++ (first line after reset never counts).
//  - Reset mid-line: partial line discarded, no pulses issued.
// TESTING
//  1 Reset: hold reset_in 3 clks with bclk toggling -> all outputs 0, no pulses.
//  2 One clean line, 64 bclk, rgb_top=col[2:0], rgb_bot=~col[2:0], latch, addr=5 -> 64 pix pulses with matching
//    col/rgb, line_valid with row 5, len 64, err 0.
//  3 Short line of 63 bclk then latch -> len 63, line_err 1, err_sticky 1 and stays 1.
//  4 65 bclk -> only 64 pix pulses, len 64, err 1; bclk rise during latch high -> next line err 1.
//  5 oe_n low 100 clks -> oe_valid with oe_time 100; low 70000 clks -> oe_time 16'hFFFF.
//  6 Rows 0..15 then 0 -> frame_cnt 1; bclk rise and latch rise same cycle -> pixel counted, len 64.

Source files
------------

// File: rtl/led_display_hub75_rx.sv
// HUB75 receive-side model: synchronises the panel pins, detects bit-clock, latch and
// output-enable edges, and rebuilds per-pixel writes, per-line summaries, OE on-times
// and a frame counter from the scan order of the row address.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no line in progress, waiting for the first bit clock
// SHIFT | pixels of the current line are being shifted in
// LATCH | latch is high; bit clocks here are protocol errors
module led_display_hub75_rx #(
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    parameter int SYNC_STAGES    = 2,
    localparam int ADDR_W        = $clog2(NUM_ROW_PIXELS / 2),
    localparam int COL_W         = $clog2(NUM_COL_PIXELS)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              bclk_in,
    input  logic [2:0]        rgb_top_in,
    input  logic [2:0]        rgb_bot_in,
    input  logic              latch_in,
    input  logic              oe_n_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              pix_valid_out,
    output logic [COL_W-1:0]  pix_col_out,
    output logic [2:0]        pix_top_rgb_out,
    output logic [2:0]        pix_bot_rgb_out,
    output logic              line_valid_out,
    output logic [ADDR_W-1:0] line_row_out,
    output logic [COL_W:0]    line_len_out,
    output logic              line_err_out,
    output logic              oe_valid_out,
    output logic [15:0]       oe_time_out,
    output logic [15:0]       frame_cnt_out,
    output logic              err_sticky_out
);

    localparam int IN_W = 9 + ADDR_W;
    localparam logic [COL_W:0] COL_MAX = (COL_W + 1)'(NUM_COL_PIXELS);

    // oe_n idles high so a released reset never looks like an OE window ending
    localparam logic [IN_W-1:0] SYNC_INIT = {2'b00, 1'b1, 6'b000000, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    logic [IN_W-1:0]   raw_pins;
    logic [IN_W-1:0]   sync_q [SYNC_STAGES];
    logic [IN_W-1:0]   synced;

    logic              s_bclk;
    logic              s_latch;
    logic              s_oe_n;
    logic [2:0]        s_top;
    logic [2:0]        s_bot;
    logic [ADDR_W-1:0] s_addr;

    logic              prev_bclk;
    logic              prev_latch;
    logic              prev_oe_n;

    logic              bclk_rise;
    logic              latch_rise;
    logic              latch_fall;
    logic              oe_rise;
    logic              oe_low;
    logic [2:0]        top_q;
    logic [2:0]        bot_q;
    logic [ADDR_W-1:0] addr_q;

    state_t            state;
    logic [COL_W:0]    col;
    logic              ovf_flag;
    logic              late_flag;
    logic              have_row;
    logic [15:0]       oe_cnt;

    logic              shift_ok;
    logic              pix_ok;
    logic              ovf_hit;
    logic              late_hit;
    logic [COL_W:0]    col_next;
    logic              line_err_c;

    assign raw_pins = {bclk_in, latch_in, oe_n_in, rgb_top_in, rgb_bot_in, addr_in};
    assign synced   = sync_q[SYNC_STAGES-1];
    assign {s_bclk, s_latch, s_oe_n, s_top, s_bot, s_addr} = synced;

    // Synchroniser chain, same depth for every pin so data stays aligned with its strobe
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_INIT;
            end
        end else begin
            sync_q[0] <= raw_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Edge-detect register: registered edge strobes plus data delayed to stay aligned
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            prev_bclk  <= 1'b0;
            prev_latch <= 1'b0;
            prev_oe_n  <= 1'b1;
            bclk_rise  <= 1'b0;
            latch_rise <= 1'b0;
            latch_fall <= 1'b0;
            oe_rise    <= 1'b0;
            oe_low     <= 1'b0;
            top_q      <= 3'b000;
            bot_q      <= 3'b000;
            addr_q     <= '0;
        end else begin
            prev_bclk  <= s_bclk;
            prev_latch <= s_latch;
            prev_oe_n  <= s_oe_n;
            bclk_rise  <= s_bclk & ~prev_bclk;
            latch_rise <= s_latch & ~prev_latch;
            latch_fall <= ~s_latch & prev_latch;
            oe_rise    <= s_oe_n & ~prev_oe_n;
            oe_low     <= ~s_oe_n;
            top_q      <= s_top;
            bot_q      <= s_bot;
            addr_q     <= s_addr;
        end
    end

    // Pixel acceptance and line error for this cycle; a bit clock coinciding with the latch
    // edge is accepted first so it lands in the line being closed
    always_comb begin
        shift_ok   = bclk_rise && (state != LATCH);
        pix_ok     = shift_ok && (col < COL_MAX);
        ovf_hit    = shift_ok && !(col < COL_MAX);
        late_hit   = bclk_rise && (state == LATCH);
        col_next   = col + {{COL_W{1'b0}}, pix_ok};
        line_err_c = (col_next != COL_MAX) || ovf_flag || ovf_hit || late_flag;
    end

    // Line FSM with registered pixel, line and frame outputs
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state           <= IDLE;
            col             <= '0;
            ovf_flag        <= 1'b0;
            late_flag       <= 1'b0;
            have_row        <= 1'b0;
            pix_valid_out   <= 1'b0;
            pix_col_out     <= '0;
            pix_top_rgb_out <= 3'b000;
            pix_bot_rgb_out <= 3'b000;
            line_valid_out  <= 1'b0;
            line_row_out    <= '0;
            line_len_out    <= '0;
            line_err_out    <= 1'b0;
            frame_cnt_out   <= 16'h0000;
            err_sticky_out  <= 1'b0;
        end else begin
            pix_valid_out  <= 1'b0;
            line_valid_out <= 1'b0;

            if (pix_ok) begin
                pix_valid_out   <= 1'b1;
                pix_col_out     <= col[COL_W-1:0];
                pix_top_rgb_out <= top_q;
                pix_bot_rgb_out <= bot_q;
            end

            if (latch_rise) begin
                line_valid_out <= 1'b1;
                line_row_out   <= addr_q;
                line_len_out   <= col_next;
                line_err_out   <= line_err_c;
                if (line_err_c) begin
                    err_sticky_out <= 1'b1;
                end
                // Row address going backwards marks the start of a new frame
                if (have_row && (addr_q < line_row_out)) begin
                    frame_cnt_out <= frame_cnt_out + 16'h0001;
                end
                have_row  <= 1'b1;
                col       <= '0;
                ovf_flag  <= 1'b0;
                late_flag <= 1'b0;
                state     <= LATCH;
            end else begin
                col <= col_next;
                if (ovf_hit) begin
                    ovf_flag <= 1'b1;
                end
                if (late_hit) begin
                    late_flag <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (bclk_rise) begin
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        state <= SHIFT;
                    end
                    LATCH: begin
                        if (latch_fall) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // OE on-time measurement, saturating, reported when oe_n returns high
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            oe_cnt       <= 16'h0000;
            oe_valid_out <= 1'b0;
            oe_time_out  <= 16'h0000;
        end else begin
            oe_valid_out <= 1'b0;
            if (oe_rise) begin
                oe_valid_out <= 1'b1;
                oe_time_out  <= oe_cnt;
                oe_cnt       <= 16'h0000;
            end else if (oe_low && (oe_cnt != 16'hFFFF)) begin
                oe_cnt <= oe_cnt + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_led_display_hub75_rx.sv
// Scoreboard bench for the HUB75 receiver: drivers push expected pixels, lines and OE
// times from a small protocol model; a negedge monitor pops and compares.
module tb_led_display_hub75_rx;

    localparam int NR = 32;
    localparam int NC = 64;
    localparam int SS = 2;
    localparam int AW = 4;
    localparam int CW = 6;

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b1;
    logic          bclk_in = 1'b0;
    logic [2:0]    rgb_top_in = 3'd0;
    logic [2:0]    rgb_bot_in = 3'd0;
    logic          latch_in = 1'b0;
    logic          oe_n_in = 1'b1;
    logic [AW-1:0] addr_in = '0;
    logic          pix_valid_out;
    logic [CW-1:0] pix_col_out;
    logic [2:0]    pix_top_rgb_out;
    logic [2:0]    pix_bot_rgb_out;
    logic          line_valid_out;
    logic [AW-1:0] line_row_out;
    logic [CW:0]   line_len_out;
    logic          line_err_out;
    logic          oe_valid_out;
    logic [15:0]   oe_time_out;
    logic [15:0]   frame_cnt_out;
    logic          err_sticky_out;

    led_display_hub75_rx #(
        .NUM_ROW_PIXELS(NR),
        .NUM_COL_PIXELS(NC),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .bclk_in        (bclk_in),
        .rgb_top_in     (rgb_top_in),
        .rgb_bot_in     (rgb_bot_in),
        .latch_in       (latch_in),
        .oe_n_in        (oe_n_in),
        .addr_in        (addr_in),
        .pix_valid_out  (pix_valid_out),
        .pix_col_out    (pix_col_out),
        .pix_top_rgb_out(pix_top_rgb_out),
        .pix_bot_rgb_out(pix_bot_rgb_out),
        .line_valid_out (line_valid_out),
        .line_row_out   (line_row_out),
        .line_len_out   (line_len_out),
        .line_err_out   (line_err_out),
        .oe_valid_out   (oe_valid_out),
        .oe_time_out    (oe_time_out),
        .frame_cnt_out  (frame_cnt_out),
        .err_sticky_out (err_sticky_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int col;
        int top;
        int bot;
    } pix_t;

    typedef struct {
        int row;
        int len;
        int err;
        int frames;
        int sticky;
    } line_t;

    pix_t  pix_q[$];
    line_t line_q[$];
    int    oe_q[$];

    int n_vec = 0;
    int n_mis = 0;

    int m_col, m_ovf, m_late, m_in_latch, m_have, m_prev, m_frames, m_sticky;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_ovf = 0; m_late = 0; m_in_latch = 0;
        m_have = 0; m_prev = 0; m_frames = 0; m_sticky = 0;
    endtask

    task automatic model_bclk(input int top, input int bot);
        pix_t p;
        if (m_in_latch != 0) begin
            m_late = 1;
        end else if (m_col < NC) begin
            p.col = m_col; p.top = top; p.bot = bot;
            pix_q.push_back(p);
            m_col++;
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic model_latch(input int row);
        line_t l;
        l.row = row;
        l.len = m_col;
        l.err = ((m_col != NC) || (m_ovf != 0) || (m_late != 0)) ? 1 : 0;
        if (l.err != 0) m_sticky = 1;
        if ((m_have != 0) && (row < m_prev)) m_frames++;
        m_prev = row;
        m_have = 1;
        l.frames = m_frames;
        l.sticky = m_sticky;
        line_q.push_back(l);
        m_col = 0; m_ovf = 0; m_late = 0;
    endtask

    // Monitor: every output pulse must match the head of its queue
    always @(negedge clk_in) begin : monitor
        pix_t  pe;
        line_t le;
        int    oe;
        if (pix_valid_out === 1'b1) begin
            if (pix_q.size() == 0) begin
                chk("pix_unexpected", 32'(pix_valid_out), 32'd0);
            end else begin
                pe = pix_q.pop_front();
                chk("pix_col", 32'(pix_col_out), pe.col);
                chk("pix_top", 32'(pix_top_rgb_out), pe.top);
                chk("pix_bot", 32'(pix_bot_rgb_out), pe.bot);
            end
        end
        if (line_valid_out === 1'b1) begin
            if (line_q.size() == 0) begin
                chk("line_unexpected", 32'(line_valid_out), 32'd0);
            end else begin
                le = line_q.pop_front();
                chk("line_row", 32'(line_row_out), le.row);
                chk("line_len", 32'(line_len_out), le.len);
                chk("line_err", 32'(line_err_out), le.err);
                chk("frame_cnt", 32'(frame_cnt_out), le.frames);
                chk("err_sticky", 32'(err_sticky_out), le.sticky);
            end
        end
        if (oe_valid_out === 1'b1) begin
            if (oe_q.size() == 0) begin
                chk("oe_unexpected", 32'(oe_valid_out), 32'd0);
            end else begin
                oe = oe_q.pop_front();
                chk("oe_time", 32'(oe_time_out), oe);
            end
        end
    end

    task automatic do_reset();
        reset_in = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            bclk_in = ~bclk_in;
        end
        bclk_in = 1'b0; latch_in = 1'b0; oe_n_in = 1'b1;
        chk("rst_pix_valid", 32'(pix_valid_out), 32'd0);
        chk("rst_pix_col", 32'(pix_col_out), 32'd0);
        chk("rst_pix_rgb", 32'({pix_top_rgb_out, pix_bot_rgb_out}), 32'd0);
        chk("rst_line_valid", 32'(line_valid_out), 32'd0);
        chk("rst_line_fields", 32'({line_row_out, line_len_out, line_err_out}), 32'd0);
        chk("rst_oe", 32'({oe_valid_out, oe_time_out}), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt_out), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky_out), 32'd0);
        @(negedge clk_in);
        reset_in = 1'b0;
        model_reset();
        repeat (4) @(negedge clk_in);
    endtask

    task automatic pixel(input int top, input int bot);
        rgb_top_in = 3'(top);
        rgb_bot_in = 3'(bot);
        repeat (2) @(negedge clk_in);
        bclk_in = 1'b1;
        model_bclk(top, bot);
        repeat (2) @(negedge clk_in);
        bclk_in = 1'b0;
    endtask

    task automatic pixels(input int n);
        for (int c = 0; c < n; c++) begin
            pixel(c & 7, ~c & 7);
        end
    endtask

    task automatic latch_line(input int row, input int late_bclk);
        addr_in = AW'(row);
        repeat (2) @(negedge clk_in);
        latch_in = 1'b1;
        model_latch(row);
        m_in_latch = 1;
        repeat (3) @(negedge clk_in);
        if (late_bclk != 0) begin
            bclk_in = 1'b1;
            model_bclk(0, 0);
            repeat (2) @(negedge clk_in);
            bclk_in = 1'b0;
            repeat (2) @(negedge clk_in);
        end
        latch_in = 1'b0;
        repeat (3) @(negedge clk_in);
        m_in_latch = 0;
    endtask

    // Last bit clock and latch rise on the same sample
    task automatic pixel_with_latch(input int top, input int bot, input int row);
        rgb_top_in = 3'(top);
        rgb_bot_in = 3'(bot);
        addr_in = AW'(row);
        repeat (2) @(negedge clk_in);
        bclk_in = 1'b1;
        latch_in = 1'b1;
        model_bclk(top, bot);
        model_latch(row);
        m_in_latch = 1;
        repeat (3) @(negedge clk_in);
        bclk_in = 1'b0;
        repeat (2) @(negedge clk_in);
        latch_in = 1'b0;
        repeat (3) @(negedge clk_in);
        m_in_latch = 0;
    endtask

    task automatic oe_window(input int n, input int check_latency);
        int cyc;
        oe_n_in = 1'b0;
        repeat (n) @(negedge clk_in);
        oe_n_in = 1'b1;
        oe_q.push_back((n > 65535) ? 65535 : n);
        if (check_latency != 0) begin
            cyc = 0;
            while ((oe_valid_out !== 1'b1) && (cyc < 20)) begin
                @(negedge clk_in);
                cyc++;
            end
            chk("oe_latency", cyc, SS + 2);
        end
        repeat (SS + 4) @(negedge clk_in);
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while (((pix_q.size() + line_q.size() + oe_q.size()) != 0) && (cyc < 50)) begin
            @(negedge clk_in);
            cyc++;
        end
        chk({tag, "_pending"}, pix_q.size() + line_q.size() + oe_q.size(), 0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // clean line, row 5
        pixels(NC);
        latch_line(5, 0);
        drain("clean_line");

        // short line then a clean one: sticky stays set
        pixels(NC - 1);
        latch_line(6, 0);
        pixels(NC);
        latch_line(7, 0);
        drain("short_line");

        // overflow line with a bit clock while latched, then a clean line carrying that error
        pixels(NC + 1);
        latch_line(8, 1);
        pixels(NC);
        latch_line(9, 0);
        drain("overflow_line");

        // latch with no pixels at all
        latch_line(10, 0);
        drain("empty_line");

        // OE windows
        oe_window(100, 1);
        oe_window(70000, 0);
        drain("oe");

        // partial line abandoned by reset
        pixels(5);
        drain("partial");
        do_reset();

        // one frame of rows 0..15, then row 0 ending with a simultaneous bclk/latch
        for (int r = 0; r < NR / 2; r++) begin
            pixels(NC);
            latch_line(r, 0);
        end
        pixels(NC - 1);
        pixel_with_latch((NC - 1) & 7, ~(NC - 1) & 7, 0);
        drain("frame");
        chk("frame_final", 32'(frame_cnt_out), 32'd1);
        chk("sticky_final", 32'(err_sticky_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
